// File: rtl/rng_pkg.sv
// Shared types and LFSR constants for the roll_rng dice generator.
package rng_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle out of reset.
module lfsr16
    import rng_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/roll_rng.sv
// Dice-roll generator: decelerating sequence of LFSR samples, then hold.
// Optional early-stop input enabled by defining ROLL_STOP_EN.
module roll_rng
    import rng_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int INIT_PERIOD = 2,
    parameter int PERIOD_STEP = 1,
    parameter int NUM_STEPS   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef ROLL_STOP_EN
    input  logic             i_stop,
`endif
    output logic [WIDTH-1:0] o_random_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(INIT_PERIOD + NUM_STEPS * PERIOD_STEP + 1);
    localparam int SW = $clog2(NUM_STEPS + 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_period;
    logic [SW-1:0]     r_step;
    logic [WIDTH-1:0]  r_out;
    logic              r_busy;
    logic              r_done;

    logic [LFSR_W-1:0] w_lfsr;
    logic [WIDTH-1:0]  w_sample;
    logic              w_update;
    logic              w_stop;

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_lfsr  (w_lfsr)
    );

    assign w_sample = WIDTH'(w_lfsr);
    assign w_update = (r_cnt == r_period - CW'(1));

`ifdef ROLL_STOP_EN
    assign w_stop = i_stop;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_step   <= '0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // An update edge always captures the sample, even when a restart coincides.
            if (r_state == S_RUN && (w_update || (w_stop && !i_start))) begin
                r_out <= w_sample;
            end
            if (i_start) begin
                r_state  <= S_RUN;
                r_cnt    <= '0;
                r_period <= CW'(INIT_PERIOD);
                r_step   <= '0;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_update) begin
                            r_cnt    <= '0;
                            r_period <= r_period + CW'(PERIOD_STEP);
                            r_step   <= r_step + SW'(1);
                            if (r_step == SW'(NUM_STEPS - 1)) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (w_stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_random_out = r_out;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_roll_rng.sv
// Self-checking bench for roll_rng against an update-schedule reference model.
// Build with ROLL_STOP_EN defined to exercise the early-stop input as well.
module tb_roll_rng;

    localparam int W     = 4;
    localparam int INIT  = 2;
    localparam int STEP  = 1;
    localparam int NS    = 3;
`ifdef ROLL_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic         i_stop;
    logic [W-1:0] o_random_out;
    logic         o_busy;
    logic         o_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0]  m_lfsr;
    int           edge_n;
    int           sched[$];
    logic [W-1:0] exp_out;
    logic         exp_busy;
    logic         exp_done;

    roll_rng #(
        .WIDTH       (W),
        .INIT_PERIOD (INIT),
        .PERIOD_STEP (STEP),
        .NUM_STEPS   (NS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
`ifdef ROLL_STOP_EN
        .i_stop       (i_stop),
`endif
        .o_random_out (o_random_out),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return (16'(v * 2)) | {15'd0, fb};
    endfunction

    function automatic int last_rel();
        int t = 0;
        for (int k = 0; k < NS; k++) t += INIT + k * STEP;
        return t;
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        sched.delete();
        exp_out  = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_edge(input logic start, input logic stop, input logic [15:0] pre);
        bit upd;
        int t;
        upd = (sched.size() > 0) && (sched[0] == edge_n);
        exp_done = 1'b0;
        if (start) begin
            if (upd) exp_out = pre[W-1:0];
            sched.delete();
            t = edge_n;
            for (int k = 0; k < NS; k++) begin
                t += INIT + k * STEP;
                sched.push_back(t);
            end
            exp_busy = 1'b1;
        end else if (STOP_EN && stop && exp_busy) begin
            exp_out = pre[W-1:0];
            sched.delete();
            exp_busy = 1'b0;
            exp_done = 1'b1;
        end else if (upd) begin
            exp_out = pre[W-1:0];
            void'(sched.pop_front());
            if (sched.size() == 0) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic tick();
        logic [15:0] pre;
        pre = m_lfsr;
        @(posedge i_clk);
        m_lfsr = lfsr_ref(m_lfsr);
        edge_n++;
        model_edge(i_start, i_stop, pre);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        edge_n  = 0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_random_out, o_busy, o_done} !== {W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h busy=%b done=%b, want all zero", o_random_out, o_busy, o_done);
        end
        checks++;
        if (dut.u_lfsr.o_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_seed: got %h want ace1", dut.u_lfsr.o_lfsr);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut.u_lfsr.o_lfsr !== m_lfsr) begin
                errors++;
                $display("FAIL idle_lfsr[%0d]: got %h want %h", i, dut.u_lfsr.o_lfsr, m_lfsr);
            end
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL idle_outputs[%0d]: got %h/%b/%b want %h/%b/%b", i, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_single_roll();
        int e0, n_done, done_rel;
        n_done = 0;
        done_rel = -1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        e0 = edge_n;
        for (int r = 0; r <= last_rel() + 3; r++) begin
            if (r > 0) tick();
            if (o_done) begin n_done++; done_rel = edge_n - e0; end
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL single_roll E%0d: got %h/%b/%b want %h/%b/%b", r, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        checks++;
        if (n_done != 1 || done_rel != last_rel()) begin
            errors++;
            $display("FAIL single_roll_done: got %0d pulses at E%0d, want 1 at E%0d", n_done, done_rel, last_rel());
        end
    endtask

    task automatic test_back_to_back();
        int e0, n_done, done_rel;
        n_done = 0;
        done_rel = -1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        e0 = edge_n;
        for (int r = 1; r <= 4 + last_rel() + 3; r++) begin
            i_start = (r == 4);
            tick();
            i_start = 1'b0;
            if (o_done) begin n_done++; done_rel = edge_n - e0; end
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL back_to_back E%0d: got %h/%b/%b want %h/%b/%b", r, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        checks++;
        if (n_done != 1 || done_rel != 4 + last_rel()) begin
            errors++;
            $display("FAIL back_to_back_done: got %0d pulses at E%0d, want 1 at E%0d", n_done, done_rel, 4 + last_rel());
        end
    endtask

    task automatic test_start_on_final();
        int e0, n_done;
        n_done = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        e0 = edge_n;
        for (int r = 1; r <= 2 * last_rel() + 3; r++) begin
            i_start = (r == last_rel());
            tick();
            i_start = 1'b0;
            if (o_done) n_done++;
            if (r == last_rel()) begin
                checks++;
                if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL final_restart_flags: got busy=%b done=%b want busy=1 done=0", o_busy, o_done);
                end
            end
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL start_on_final E%0d: got %h/%b/%b want %h/%b/%b", edge_n - e0, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL start_on_final_done: got %0d pulses want 1", n_done);
        end
    endtask

    task automatic test_reset_mid_roll();
        int n_done;
        n_done = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        #1 i_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({o_random_out, o_busy, o_done} !== {W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got %h/%b/%b want all zero", o_random_out, o_busy, o_done);
        end
        checks++;
        if (dut.u_lfsr.o_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL mid_reset_seed: got %h want ace1", dut.u_lfsr.o_lfsr);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int r = 1; r <= last_rel() + 3; r++) begin
            tick();
            if (o_done) n_done++;
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL post_reset_roll E%0d: got %h/%b/%b want %h/%b/%b", r, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL post_reset_done: got %0d pulses want 1", n_done);
        end
    endtask

    task automatic test_stop();
        int e0, done_rel;
        done_rel = -1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        e0 = edge_n;
        for (int r = 1; r <= 8; r++) begin
            i_stop = (r == 3);
            tick();
            i_stop = 1'b0;
            if (o_done && done_rel < 0) done_rel = edge_n - e0;
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL stop_roll E%0d: got %h/%b/%b want %h/%b/%b", r, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        checks++;
        if (done_rel != 3) begin
            errors++;
            $display("FAIL stop_done_edge: got E%0d want E3", done_rel);
        end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        checks++;
        if ({o_random_out, o_busy, o_done} !== {exp_out, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_idle: got %h/%b/%b want %h/0/0", o_random_out, o_busy, o_done, exp_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            i_start = ($urandom_range(0, 9) == 0);
            i_stop  = STOP_EN && ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if ({o_random_out, o_busy, o_done} !== {exp_out, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b", i, o_random_out, o_busy, o_done, exp_out, exp_busy, exp_done);
            end
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
        repeat (last_rel() + 2) tick();
        checks++;
        if (dut.u_lfsr.o_lfsr !== m_lfsr) begin
            errors++;
            $display("FAIL random_lfsr: got %h want %h", dut.u_lfsr.o_lfsr, m_lfsr);
        end
    endtask

    initial begin
        test_reset();
        test_single_roll();
        test_back_to_back();
        test_start_on_final();
        test_reset_mid_roll();
        if (STOP_EN) test_stop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
